// File: rtl/video_out_switch.sv
// Frame-synchronous selector for NUM_SRC indexed-pixel video streams: switches on a
// vsync leading edge, blanks for BLANK_FRAMES frames, and outputs palette RGB two cycles later.
module video_out_switch #(
  parameter int NUM_SRC        = 2,
  parameter int SEL_W          = 1,
  parameter int RGB_BITS       = 3,
  parameter int BLANK_FRAMES   = 2,
  parameter int VS_ACTIVE_HIGH = 1
) (
  input  logic                   clk_dot4x,
  input  logic                   rst,
  input  logic [SEL_W-1:0]       sel_req,
  input  logic [NUM_SRC*4-1:0]   src_color,
  input  logic [NUM_SRC-1:0]     src_hsync,
  input  logic [NUM_SRC-1:0]     src_vsync,
  input  logic [NUM_SRC-1:0]     src_active,
  output logic [RGB_BITS-1:0]    red,
  output logic [RGB_BITS-1:0]    green,
  output logic [RGB_BITS-1:0]    blue,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   active,
  output logic [SEL_W-1:0]       sel_cur,
  output logic                   switching
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam logic [3:0] BLANK_INIT = 4'(BLANK_FRAMES);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_cur_q, sel_cur_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             vs_prev_q;
  logic             vs_now, vs_lead, req_valid;

  assign vs_now    = src_vsync[sel_cur_q];
  assign vs_lead   = (VS_ACTIVE_HIGH != 0) ? (vs_now & ~vs_prev_q) : (~vs_now & vs_prev_q);
  assign req_valid = int'(sel_req) < NUM_SRC;

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sel_cur_d = sel_cur_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && (sel_req != sel_cur_q)) begin
          target_d = sel_req;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (req_valid) target_d = sel_req;
        if (target_d == sel_cur_q) begin
          state_d = ST_IDLE;
        end else if (vs_lead) begin
          sel_cur_d = target_d;
          cnt_d     = BLANK_INIT;
          state_d   = (BLANK_FRAMES == 0) ? ST_IDLE : ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (vs_lead) begin
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_cur_q <= '0;
      target_q  <= '0;
      cnt_q     <= 4'd0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_cur_q <= sel_cur_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      // Track whichever source drives next cycle, so a switch never sees a false edge.
      vs_prev_q <= src_vsync[sel_cur_d];
    end
  end

  function automatic logic [23:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    palette = 24'h000000;
      4'd1:    palette = 24'hFFFFFF;
      4'd2:    palette = 24'h68372B;
      4'd3:    palette = 24'h70A4B2;
      4'd4:    palette = 24'h6F3D86;
      4'd5:    palette = 24'h588D43;
      4'd6:    palette = 24'h352879;
      4'd7:    palette = 24'hB8C76F;
      4'd8:    palette = 24'h6F4F25;
      4'd9:    palette = 24'h433900;
      4'd10:   palette = 24'h9A6759;
      4'd11:   palette = 24'h444444;
      4'd12:   palette = 24'h6C6C6C;
      4'd13:   palette = 24'h9AD284;
      4'd14:   palette = 24'h6C5EB5;
      default: palette = 24'h959595;
    endcase
  endfunction

  logic [3:0] mux_color;

  always_comb begin
    mux_color = 4'h0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_cur_q == SEL_W'(k)) mux_color = src_color[4*k +: 4];
    end
  end

  logic [3:0]          s1_color_q;
  logic                s1_hs_q, s1_vs_q, s1_act_q, s1_blank_q;
  logic [RGB_BITS-1:0] red_q, green_q, blue_q;
  logic                hs_q, vs_q, act_q;
  logic [23:0]         pal_rgb;
  logic                s2_act;

  assign pal_rgb = palette(s1_color_q);
  assign s2_act  = s1_act_q & ~s1_blank_q;

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      s1_color_q <= 4'h0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_act_q   <= 1'b0;
      s1_blank_q <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      act_q      <= 1'b0;
    end else begin
      s1_color_q <= mux_color;
      s1_hs_q    <= src_hsync[sel_cur_q];
      s1_vs_q    <= src_vsync[sel_cur_q];
      s1_act_q   <= src_active[sel_cur_q];
      s1_blank_q <= (state_q == ST_BLANK);
      // Keep the top RGB_BITS of each 8-bit channel.
      red_q      <= s2_act ? RGB_BITS'(pal_rgb[23:16] >> (8 - RGB_BITS)) : '0;
      green_q    <= s2_act ? RGB_BITS'(pal_rgb[15:8]  >> (8 - RGB_BITS)) : '0;
      blue_q     <= s2_act ? RGB_BITS'(pal_rgb[7:0]   >> (8 - RGB_BITS)) : '0;
      hs_q       <= s1_hs_q;
      vs_q       <= s1_vs_q;
      act_q      <= s2_act;
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign active    = act_q;
  assign sel_cur   = sel_cur_q;
  assign switching = (state_q != ST_IDLE);

endmodule

// File: doc/video_out_switch.md
Name: video_out_switch

Overview:
- Parametrised successor to the fixed composite/VGA output select at board top level.
- Takes NUM_SRC independent pixel/sync streams (composite, VGA, HDMI, ...), each carrying a 4-bit indexed pixel plus hsync/vsync/active.
- Switches between streams only on a frame boundary, then blanks for a programmable number of frames so downstream encoders resync cleanly.
- Translates the selected index to RGB of configurable depth through a registered pipeline.

Parameters:
NUM_SRC, 2, number of input streams (2..8)
SEL_W, 1, select width, equals clog2(NUM_SRC) and is at least 1
RGB_BITS, 3, bits per colour channel on output (1..8)
BLANK_FRAMES, 2, frames of forced blanking after a switch (0..15)
VS_ACTIVE_HIGH, 1, vsync polarity; 1 means the leading edge is 0->1

Ports:
clk_dot4x  in  1  4x dot clock, sole clock
rst  in  1  synchronous reset, active-high
sel_req  in  SEL_W  requested source index, level-sensitive
src_color  in  NUM_SRC*4  packed pixel indices; source k occupies bits [4k+3:4k]
src_hsync  in  NUM_SRC  per-source hsync
src_vsync  in  NUM_SRC  per-source vsync
src_active  in  NUM_SRC  per-source display-active
red  out  RGB_BITS  red channel
green  out  RGB_BITS  green channel
blue  out  RGB_BITS  blue channel
hsync  out  1  hsync of the current source, pipeline-aligned
vsync  out  1  vsync of the current source, pipeline-aligned
active  out  1  active of the current source, pipeline-aligned; forced 0 while blanking
sel_cur  out  SEL_W  source currently driving the outputs
switching  out  1  high while in ARMED or BLANK

Behaviour:
- Clock and reset: single clock clk_dot4x; synchronous active-high reset rst.
- Reset state: state=IDLE, sel_cur=0, target=0, blank counter=0, all pipeline registers cleared.
  - red/green/blue/hsync/vsync/active/switching all read 0 on the first cycle after reset.
- Reset mid-switch: abandons the switch immediately; sel_cur returns to 0.
- Frame edge detect: vs_prev registers the vsync of sel_cur.
  - vs_lead = leading edge per VS_ACTIVE_HIGH (current vs the registered value).
  - Whenever sel_cur changes, vs_prev loads the new source's current vsync, so no false edge occurs.
- Request validity: sel_req >= NUM_SRC is invalid and treated as equal to sel_cur (ignored).
- FSM states:
  - IDLE: if a valid sel_req != sel_cur, latch target=sel_req and go to ARMED.
  - ARMED: each cycle, target follows a valid sel_req.
    - If target == sel_cur, return to IDLE with no blanking.
    - On vs_lead: sel_cur <= target, counter <= BLANK_FRAMES, then go to BLANK, or straight to IDLE if BLANK_FRAMES == 0.
  - BLANK: sel_req is ignored. On each vs_lead of the new source, the counter decrements; at the transition 1->0, go to IDLE.
    - A request pending after BLANK is picked up normally in IDLE.
- switching = (state != IDLE).
- Pipeline, fixed 2-cycle latency from inputs to outputs:
  - Stage 1 registers the selected color, hsync, vsync and active (mux on sel_cur).
  - Stage 2 registers the palette lookup and delays the syncs one further cycle.
  - The sel_cur change takes effect at stage 1 on the cycle after vs_lead; syncs from the old source are never mixed with pixels from the new one.
- Palette: 16-entry standard VIC-II table at 8 bits per channel, identical values to the existing color module. Output is the top RGB_BITS MSBs of each channel.
- Blanking:
  - When stage-2 active=0, or the FSM was in BLANK when stage 1 was loaded, output rgb=0 and active=0.
  - hsync/vsync keep passing through during BLANK.
- Width rules: indices are unsigned; no arithmetic beyond the 4-bit blank counter.
- Simultaneous events:
  - vs_lead in the same cycle sel_req changes while ARMED: the new valid sel_req is used as target.
  - If that value equals sel_cur, no switch occurs.

Test Plan:
- Reset with rst=1 for 3 cycles, src0 color=1, active=1 -> first cycle after reset all outputs 0; 2 cycles after release rgb = 7/7/7 (white, RGB_BITS=3) and sel_cur=0.
- sel_req 0->1 mid-frame -> switching=1 and sel_cur stays 0 until src0 vsync rises; next cycle sel_cur=1; then active=0 and rgb=0 for exactly 2 src1 frames; then src1 pixels appear with 2-cycle latency and switching=0.
- sel_req 0->1 then back to 0 before the src0 vsync edge -> returns to IDLE, no blanking, sel_cur stays 0 throughout.
- NUM_SRC=3, sel_req=3 -> ignored, switching remains 0; then sel_req=2 -> switch to source 2 at the next src0 vsync.
- rst asserted during BLANK of a 0->1 switch -> next cycle sel_cur=0 and switching=0; with sel_req still 1, re-arms and switches on the next src0 vsync.
- BLANK_FRAMES=0, VS_ACTIVE_HIGH=0 -> switch happens on the src vsync 1->0 edge; no active=0 gap beyond the source's own timing.
